even_parity_serial_tx: RTL and testbench

Serial transmitter for even-parity-protected bytes; the sending end of the even parity check path.
- Accepts a parallel word through a valid/ready handshake.
- Computes even parity.
- Shifts out a UART-style frame, LSB first: start bit, data bits, parity bit, stop bit.
- Sits between a byte producer and a serial link whose receiver runs the even parity checker.

---
 rtl/even_parity_pkg.sv | 23 ++
 rtl/parity_bit_timer.sv | 30 +++
 rtl/even_parity_serial_tx.sv | 131 +++++++++++++
 tb/tb_even_parity_serial_tx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/even_parity_pkg.sv
// Shared types and helpers for the even-parity serial link (transmitter and checker).
package even_parity_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam int MAX_DATA_W = 16;

  // Callers zero-extend narrower words; zero bits do not change the parity.
  function automatic logic evenParity(input logic [MAX_DATA_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/parity_bit_timer.sv
// Bit-time counter: strobes o_bit_tick on the last cycle of every CLKS_PER_BIT-cycle bit.
module parity_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clear,
  output logic o_bit_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_bit_tick = i_en && (r_cnt == LAST_CNT);

  // With CLKS_PER_BIT=1 the last count is 0, so the counter never leaves 0.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (o_bit_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/even_parity_serial_tx.sv
// Even-parity UART-style transmitter: start bit, DATA_W data bits LSB first, parity, stop.
module even_parity_serial_tx
  import even_parity_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  output logic              o_tx_out,
  output logic              o_tx_busy,
  output logic              o_parity_out,
  output logic              o_frame_done
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_t            r_state;
  state_t            w_stateNext;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shiftNext;
  logic [BIT_W-1:0]  r_bitCnt;
  logic [BIT_W-1:0]  w_bitCntNext;
  logic              r_tx;
  logic              r_ready;
  logic              r_busy;
  logic              r_parity;
  logic              r_done;
  logic              w_txNext;
  logic              w_doneNext;
  logic              w_parityNext;
  logic              w_accept;
  logic              w_bitTick;
  logic              w_timerEn;

  assign w_accept  = i_data_valid && r_ready;
  assign w_timerEn = (r_state != IDLE);

  parity_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (w_timerEn),
    .i_clear    (w_accept),
    .o_bit_tick (w_bitTick)
  );

  // Outputs are computed from the next state so every port comes straight from a flop.
  always_comb begin
    w_stateNext  = r_state;
    w_shiftNext  = r_shift;
    w_bitCntNext = r_bitCnt;
    w_parityNext = r_parity;
    w_doneNext   = 1'b0;
    w_txNext     = IDLE_LEVEL;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_stateNext  = START;
          w_shiftNext  = i_data_in;
          w_bitCntNext = '0;
          w_parityNext = evenParity(MAX_DATA_W'(i_data_in));
        end
      end
      START: begin
        if (w_bitTick) w_stateNext = DATA;
      end
      DATA: begin
        if (w_bitTick) begin
          w_shiftNext  = r_shift >> 1;
          w_bitCntNext = r_bitCnt + BIT_W'(1);
          if (r_bitCnt == LAST_BIT) w_stateNext = PARITY;
        end
      end
      PARITY: begin
        if (w_bitTick) w_stateNext = STOP;
      end
      STOP: begin
        if (w_bitTick) begin
          w_stateNext = IDLE;
          w_doneNext  = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase

    case (w_stateNext)
      IDLE:    w_txNext = IDLE_LEVEL;
      START:   w_txNext = START_BIT;
      DATA:    w_txNext = w_shiftNext[0];
      PARITY:  w_txNext = w_parityNext;
      STOP:    w_txNext = STOP_BIT;
      default: w_txNext = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitCnt <= '0;
      r_tx     <= IDLE_LEVEL;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_parity <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_shift  <= w_shiftNext;
      r_bitCnt <= w_bitCntNext;
      r_tx     <= w_txNext;
      r_ready  <= (w_stateNext == IDLE);
      r_busy   <= (w_stateNext != IDLE);
      r_parity <= w_parityNext;
      r_done   <= w_doneNext;
    end
  end

  assign o_data_ready = r_ready;
  assign o_tx_out     = r_tx;
  assign o_tx_busy    = r_busy;
  assign o_parity_out = r_parity;
  assign o_frame_done = r_done;

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Bench for even_parity_serial_tx: frame-level model compared every cycle, plus directed literal checks.
module tb_even_parity_serial_tx;

  logic       clk = 1'b0;
  logic       tbRst[2];
  logic       tbValid[2];
  logic [7:0] tbData[2];
  logic       dutReady[2];
  logic       dutTx[2];
  logic       dutBusy[2];
  logic       dutParity[2];
  logic       dutDone[2];

  int errorCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  even_parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut0 (
    .i_clk        (clk),
    .i_rst        (tbRst[0]),
    .i_data_in    (tbData[0]),
    .i_data_valid (tbValid[0]),
    .o_data_ready (dutReady[0]),
    .o_tx_out     (dutTx[0]),
    .o_tx_busy    (dutBusy[0]),
    .o_parity_out (dutParity[0]),
    .o_frame_done (dutDone[0])
  );

  even_parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut1 (
    .i_clk        (clk),
    .i_rst        (tbRst[1]),
    .i_data_in    (tbData[1]),
    .i_data_valid (tbValid[1]),
    .o_data_ready (dutReady[1]),
    .o_tx_out     (dutTx[1]),
    .o_tx_busy    (dutBusy[1]),
    .o_parity_out (dutParity[1]),
    .o_frame_done (dutDone[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, want %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int k, input logic rst, input logic valid, input logic [7:0] data);
    tbRst[k]   = rst;
    tbValid[k] = valid;
    tbData[k]  = data;
  endtask

  // Frame model: a frame is an 11-bit vector {stop, parity, data, start}; the line shows bit pos/cpb.
  int         mPos[2];
  logic [10:0] mFrame[2];
  logic       mReady[2];
  logic       mBusy[2];
  logic       mTx[2];
  logic       mParity[2];
  logic       mDone[2];
  logic       mValid[2] = '{1'b0, 1'b0};
  logic       mRstSeen[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int cpb;
      cpb = (k == 0) ? 1 : 4;
      if (tbRst[k]) begin
        mValid[k]   = 1'b1;
        mRstSeen[k] = 1'b1;
        mPos[k]     = -1;
        mParity[k]  = 1'b0;
        mDone[k]    = 1'b0;
      end else begin
        mRstSeen[k] = 1'b0;
        mDone[k]    = 1'b0;
        if (mPos[k] < 0) begin
          if (tbValid[k] && mReady[k]) begin
            mPos[k]    = 0;
            mFrame[k]  = {1'b1, ^tbData[k], tbData[k], 1'b0};
            mParity[k] = ^tbData[k];
          end
        end else begin
          mPos[k]++;
          if (mPos[k] == 11 * cpb) begin
            mPos[k]  = -1;
            mDone[k] = 1'b1;
          end
        end
      end
      mReady[k] = (mPos[k] < 0);
      mBusy[k]  = !mReady[k];
      mTx[k]    = mReady[k] ? 1'b1 : mFrame[k][mPos[k] / cpb];
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mValid[k]) begin
        checkOutput($sformatf("cycTx%0d", k), dutTx[k], mTx[k]);
        checkOutput($sformatf("cycReady%0d", k), dutReady[k], mReady[k]);
        checkOutput($sformatf("cycBusy%0d", k), dutBusy[k], mBusy[k]);
        checkOutput($sformatf("cycParity%0d", k), dutParity[k], mParity[k]);
        checkOutput($sformatf("cycDone%0d", k), dutDone[k], mDone[k]);
      end
    end
  end

  // Loopback even-parity receiver on the CLKS_PER_BIT=1 line.
  logic       rxActive = 1'b0;
  int         rxIdx;
  logic [9:0] rxBits;
  logic [7:0] rxDataQ[$];
  logic       rxErrQ[$];

  always @(negedge clk) begin
    if (mValid[0]) begin
      if (mRstSeen[0]) begin
        rxActive = 1'b0;
      end else if (!rxActive) begin
        if (dutTx[0] === 1'b0) begin
          rxActive = 1'b1;
          rxIdx    = 0;
        end
      end else begin
        rxBits[rxIdx] = dutTx[0];
        rxIdx++;
        if (rxIdx == 10) begin
          rxDataQ.push_back(rxBits[7:0]);
          rxErrQ.push_back(((^rxBits[8:0]) !== 1'b0) || (rxBits[9] !== 1'b1));
          rxActive = 1'b0;
        end
      end
    end
  end

  logic waveBuf[64];
  logic readyBuf[64];

  task automatic sendFrame(input int k, input logic [7:0] d, output int doneCycle, output logic parSeen);
    @(negedge clk);
    applyStimulus(k, 1'b0, 1'b1, d);
    doneCycle = -1;
    parSeen   = 1'bx;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) begin
        applyStimulus(k, 1'b0, 1'b0, 8'h00);
        parSeen = dutParity[k];
      end
      waveBuf[i] = dutTx[k];
      if (dutDone[k] === 1'b1) begin
        doneCycle = i;
        break;
      end
    end
  endtask

  task automatic checkRx(input string name, input logic [7:0] want);
    checkOutput({name, "RxCount"}, rxDataQ.size(), 1);
    if (rxDataQ.size() >= 1) begin
      checkOutput({name, "RxData"}, rxDataQ[0], want);
      checkOutput({name, "RxErr"}, rxErrQ[0], 0);
    end
    rxDataQ.delete();
    rxErrQ.delete();
  endtask

  initial begin
    int         doneCycle;
    logic       par;
    int         cnt;
    logic [7:0] words[6]  = '{8'h00, 8'h01, 8'h02, 8'h0E, 8'hD9, 8'hE8};
    logic       parExp[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int         expA6[11] = '{0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 1};

    applyStimulus(0, 1'b1, 1'b1, 8'hA6);
    applyStimulus(1, 1'b1, 1'b1, 8'h3C);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checkOutput("resetTx", dutTx[k], 1);
      checkOutput("resetReady", dutReady[k], 1);
      checkOutput("resetBusy", dutBusy[k], 0);
      checkOutput("resetDone", dutDone[k], 0);
      checkOutput("resetParity", dutParity[k], 0);
      applyStimulus(k, 1'b0, 1'b0, 8'h00);
    end
    @(negedge clk);
    checkOutput("noAcceptInReset", dutBusy[0], 0);
    rxDataQ.delete();
    rxErrQ.delete();

    $display("[TB] frame 0xA6, CLKS_PER_BIT=1");
    sendFrame(0, 8'hA6, doneCycle, par);
    for (int i = 0; i < 11; i++) checkOutput($sformatf("a6Bit%0d", i), waveBuf[i + 1], expA6[i]);
    checkOutput("a6Parity", par, 0);
    checkOutput("a6DoneCycle", doneCycle, 12);
    checkRx("a6", 8'hA6);

    $display("[TB] parity table");
    for (int w = 0; w < 6; w++) begin
      sendFrame(0, words[w], doneCycle, par);
      checkOutput($sformatf("parity_%02h", words[w]), par, parExp[w]);
      checkOutput($sformatf("doneCycle_%02h", words[w]), doneCycle, 12);
      checkRx($sformatf("tbl_%02h", words[w]), words[w]);
    end

    $display("[TB] frame 0x01, CLKS_PER_BIT=4");
    sendFrame(1, 8'h01, doneCycle, par);
    checkOutput("cpb4Parity", par, 1);
    checkOutput("cpb4DoneCycle", doneCycle, 45);
    cnt = 0;
    for (int i = 1; i <= 44; i++) begin
      logic want;
      want = (i <= 4) ? 1'b0 : (i <= 8) ? 1'b1 : (i <= 36) ? 1'b0 : 1'b1;
      if (waveBuf[i] !== want) cnt++;
    end
    checkOutput("cpb4WaveBadSamples", cnt, 0);

    $display("[TB] back-to-back 0x55, 0x0F");
    rxDataQ.delete();
    rxErrQ.delete();
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b1, 8'h55);
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      readyBuf[i] = dutReady[0];
      waveBuf[i]  = dutTx[0];
      if (i == 1)  applyStimulus(0, 1'b0, 1'b1, 8'h0F);
      if (i == 24) applyStimulus(0, 1'b0, 1'b0, 8'h00);
    end
    cnt = 0;
    for (int i = 1; i <= 23; i++) if (readyBuf[i] === 1'b1) cnt++;
    checkOutput("b2bReadyCycles", cnt, 1);
    checkOutput("b2bReadyAt12", readyBuf[12], 1);
    checkOutput("b2bIdleHigh", waveBuf[12], 1);
    checkOutput("b2bStart2", waveBuf[13], 0);
    checkOutput("b2bRxCount", rxDataQ.size(), 2);
    if (rxDataQ.size() == 2) begin
      checkOutput("b2bRxData0", rxDataQ[0], 8'h55);
      checkOutput("b2bRxErr0", rxErrQ[0], 0);
      checkOutput("b2bRxData1", rxDataQ[1], 8'h0F);
      checkOutput("b2bRxErr1", rxErrQ[1], 0);
    end

    $display("[TB] abort 0xFF during data bit 3");
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b1, 8'hFF);
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (dutDone[0] === 1'b1) cnt++;
      if (i == 1) applyStimulus(0, 1'b0, 1'b0, 8'h00);
      if (i == 5) applyStimulus(0, 1'b1, 1'b0, 8'h00);
      if (i == 6) begin
        checkOutput("abortTx", dutTx[0], 1);
        checkOutput("abortBusy", dutBusy[0], 0);
        checkOutput("abortReady", dutReady[0], 1);
        applyStimulus(0, 1'b0, 1'b0, 8'h00);
      end
    end
    checkOutput("abortNoDone", cnt, 0);
    rxDataQ.delete();
    rxErrQ.delete();
    sendFrame(0, 8'h03, doneCycle, par);
    checkOutput("after03Parity", par, 0);
    checkOutput("after03DoneCycle", doneCycle, 12);
    checkRx("after03", 8'h03);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
